// File: rtl/cordic_handoff_buffer.sv
// Handoff buffer between CORDIC passes: captures one selected operand when the
// iteration index reaches CAPTURE_ITER, queues it in a small FIFO and presents
// it as the Z reload operand (with X gain-compensated, Y zeroed) for the next pass.
module cordic_handoff_buffer #(
   parameter int                WIDTH        = 16,
   parameter int                IW           = 4,
   parameter int                CAPTURE_ITER = 10,
   parameter logic [WIDTH-1:0]  X_INIT       = 'h04D4,
   parameter int                DEPTH        = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH-1:0]             Xout,
   input  logic [WIDTH-1:0]             Yout,
   input  logic [WIDTH-1:0]             Zout,
   input  logic [IW-1:0]                i,
   input  logic                         iter_valid,
   input  logic [1:0]                   sel,
   input  logic                         out_ready,
   input  logic                         clear_ovf,
   output logic [WIDTH-1:0]             X_H,
   output logic [WIDTH-1:0]             Y_H,
   output logic [WIDTH-1:0]             Z_H,
   output logic                         out_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0]           FULL_CNT = CW'(DEPTH);
   localparam logic [IW-1:0]           CAP_IDX  = IW'(CAPTURE_ITER);
   localparam logic signed [WIDTH-1:0] MIN_V    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] MAX_V    = {1'b0, {(WIDTH-1){1'b1}}};

   // Two's complement negation; the most negative value has no positive
   // counterpart, so it clamps to the most positive value.
   function automatic logic signed [WIDTH-1:0] neg_sat(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] r;
      if (v == MIN_V) begin
         r = MAX_V;
      end else begin
         r = -v;
      end
      return r;
   endfunction

   // Control state
   logic                    match_q;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    ovf_q, ovf_d;
   logic                    vld_q;

   // Data state (storage is not reset; only its occupancy is)
   logic signed [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0]        x_h_q, y_h_q, z_h_q;

   logic                    match, capture, pop, full, push, drop;
   logic signed [WIDTH-1:0] wdata;
   logic signed [WIDTH-1:0] head_d;

   // Capture edge detection, operand select, FIFO bookkeeping and next head
   always_comb begin
      match    = iter_valid && (i == CAP_IDX);
      capture  = match && !match_q;
      full     = (count_q == FULL_CNT);
      pop      = (count_q != '0) && out_ready;
      push     = capture && (!full || pop);
      drop     = capture && full && !pop;

      wdata = $signed(Yout);
      case (sel)
         2'd0: wdata = $signed(Yout);
         2'd1: wdata = $signed(Xout);
         2'd2: wdata = $signed(Zout);
         2'd3: wdata = neg_sat($signed(Yout));
         default: wdata = $signed(Yout);
      endcase

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      ovf_d = ovf_q;
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clear_ovf) begin
         ovf_d = 1'b0;
      end

      // The new head may be the entry being written this very cycle.
      if (push && (rd_ptr_d == wr_ptr_q)) begin
         head_d = wdata;
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Control registers: edge history, pointers, occupancy, sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         match_q  <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         match_q  <= match;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         vld_q    <= (count_d != '0);
      end
   end

   // FIFO storage write at the tail
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Registered reload operands, zero whenever no entry is presented
   always_ff @(posedge clk) begin
      if (reset) begin
         x_h_q <= '0;
         y_h_q <= '0;
         z_h_q <= '0;
      end else begin
         x_h_q <= (count_d != '0) ? X_INIT : '0;
         y_h_q <= '0;
         z_h_q <= (count_d != '0) ? head_d : '0;
      end
   end

   assign X_H       = x_h_q;
   assign Y_H       = y_h_q;
   assign Z_H       = z_h_q;
   assign out_valid = vld_q;
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule
